fifo_lifo_sc: RTL and testbench
===============================

Name: fifo_lifo_sc

Overview:
Single-clock, parametrised FIFO/LIFO buffer; successor to the dual-clock FIFO/LIFO DUT.
- Generalises data width and depth, and selects queue or stack ordering at elaboration.
- Adds an occupancy count, almost-full/almost-empty thresholds, a read-valid strobe and sticky overflow/underflow error flags.
- Sits between a producer and a consumer in the same clock domain, behind the same tb/top harness style.

Parameters:
WIDTH, 32, data word width in bits (>=1)
DEPTH, 16, number of entries; power of 2, >=4
MODE, 0, 0 = FIFO (queue), 1 = LIFO (stack)
ALMFULL_TH, DEPTH-2, Almfull asserted when Count >= ALMFULL_TH
ALMEMPTY_TH, 2, Almempty asserted when Count <= ALMEMPTY_TH

Ports:
Clk  in  1  sole clock, rising-edge
Rst  in  1  asynchronous, active-high reset
Datain  in  WIDTH  write data
Wren  in  1  write request
Rden  in  1  read request
Clrerr  in  1  synchronous clear of Overflow/Underflow
Dataout  out  WIDTH  registered read data
Rdvalid  out  1  Dataout updated by an accepted read this cycle
Full  out  1  Count == DEPTH
Empty  out  1  Count == 0
Almfull  out  1  Count >= ALMFULL_TH
Almempty  out  1  Count <= ALMEMPTY_TH
Count  out  $clog2(DEPTH)+1  current occupancy
Overflow  out  1  sticky: write rejected
Underflow  out  1  sticky: read rejected

Behaviour:
Reset (async assert, sync release):
- Count=0, pointers=0, Dataout=0, Rdvalid=0, Full=0, Overflow=0, Underflow=0, Almfull=0.
- Empty=1, Almempty=1.
- Storage array is not reset.
- Reset mid-operation drops any in-flight Rdvalid immediately.

Acceptance, evaluated on flag state before the edge:
- wr_ok = Wren & (!Full | Rden).
- rd_ok = Rden & !Empty.
- Full with both requests: both accepted, Count unchanged.
- Empty with both requests: write accepted, read rejected.

Read latency:
- Accepted read at edge N: Dataout and Rdvalid=1 are visible after edge N.
- Rdvalid is a single-cycle strobe per accepted read.
- Dataout holds its last value when no read is accepted.

FIFO (MODE=0):
- Write pointer and read pointer, each $clog2(DEPTH) bits, wrap modulo DEPTH.
- Write stores at wptr then increments it; read returns mem[rptr] then increments it.
- Simultaneous accepted read and write: read returns the oldest entry, new data is appended.

LIFO (MODE=1):
- Single top pointer, equal to Count.
- Write stores at mem[Count], Count+1.
- Read returns mem[Count-1], Count-1.
- Simultaneous accepted read and write: Dataout = mem[Count-1] (old top); Datain overwrites mem[Count-1]; Count unchanged.

Count and flags:
- Count += wr_ok - rd_ok.
- Full, Empty, Almfull and Almempty are decoded from the Count register, so they update on the same edge as Count.
- Count never exceeds DEPTH and never goes below 0.

Errors:
- Overflow set on the edge where Wren=1 and wr_ok=0.
- Underflow set on the edge where Rden=1 and rd_ok=0.
- Both are sticky until Rst or Clrerr.
- Clrerr has priority over a same-cycle set: the flag clears.
- A rejected request modifies neither storage nor Count.

Decomposition:
- Package fifo_lifo_pkg: MODE_FIFO=0, MODE_LIFO=1, and a clog2 helper function used for pointer and Count widths.
- Sub-module buf_mem: WIDTH x DEPTH array with synchronous write and asynchronous read, addressed by separate write and read indices.
- fifo_lifo_sc contains the pointer/count control, flag decode, error logic and the Dataout register.

Test Plan:
1. FIFO, DEPTH=4: write 0xA,0xB,0xC,0xD -> Full=1, Count=4, Almfull=1. Then 4 reads -> Dataout A,B,C,D, each with a Rdvalid pulse one cycle after its request. Empty=1 at end.
2. LIFO, DEPTH=4: write 1,2,3 then 3 reads -> Dataout 3,2,1. Count goes 3,2,1,0; Empty=1.
3. Overflow/underflow: FIFO full, Wren alone -> Overflow=1, Count stays 4, contents unchanged. Drain to empty, Rden -> Underflow=1, Rdvalid=0. Pulse Clrerr -> both 0.
4. Simultaneous requests: FIFO full with Wren=Rden=1, Datain=0xE -> Dataout=oldest, Count stays 4, 0xE read last. LIFO with Count=2 (top=0x5), Wren=Rden=1, Datain=0x9 -> Dataout=0x5, next read=0x9. Empty with both -> Count=1, Underflow=1.
5. Wrap-around: FIFO DEPTH=4, 10 interleaved write/read pairs with values 0..9 -> output order 0..9, no error flags.
6. Async reset mid-stream: assert Rst between edges with Count=3 -> Count=0, Empty=1, Rdvalid=0, Dataout=0 without waiting for a clock edge. After release, write 0x7 and read -> 0x7.

Source files
------------

// File: rtl/fifo_lifo_pkg.sv
// fifo_lifo_pkg: shared constants and width helper for fifo_lifo_sc.
// Provides ordering-mode encodings and a clog2 used for pointer/count widths.
package fifo_lifo_pkg;

  localparam int MODE_FIFO = 0;
  localparam int MODE_LIFO = 1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/buf_mem.sv
// buf_mem: WIDTH x DEPTH storage, synchronous write, asynchronous read.
// Ports: i_clk, i_we, i_waddr, i_wdata (write side); i_raddr, o_rdata (read).
module buf_mem #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fifo_lifo_sc.sv
// fifo_lifo_sc: single-clock FIFO/LIFO buffer with occupancy, thresholds,
// read-valid strobe and sticky error flags.
// Ports: Clk, Rst (async high); Datain/Wren/Rden/Clrerr in;
// Dataout/Rdvalid, Full/Empty/Almfull/Almempty, Count, Overflow/Underflow out.
module fifo_lifo_sc
  import fifo_lifo_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int DEPTH       = 16,
  parameter int MODE        = MODE_FIFO,
  parameter int ALMFULL_TH  = DEPTH - 2,
  parameter int ALMEMPTY_TH = 2
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic [WIDTH-1:0]      Datain,
  input  logic                  Wren,
  input  logic                  Rden,
  input  logic                  Clrerr,
  output logic [WIDTH-1:0]      Dataout,
  output logic                  Rdvalid,
  output logic                  Full,
  output logic                  Empty,
  output logic                  Almfull,
  output logic                  Almempty,
  output logic [clog2(DEPTH):0] Count,
  output logic                  Overflow,
  output logic                  Underflow
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] LP_DEPTH = CW'(DEPTH);
  localparam logic [CW-1:0] LP_AF    = CW'(ALMFULL_TH);
  localparam logic [CW-1:0] LP_AE    = CW'(ALMEMPTY_TH);

  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_dout;
  logic             r_rdvalid;
  logic             r_ovf;
  logic             r_unf;

  logic             w_full;
  logic             w_empty;
  logic             w_wr_ok;
  logic             w_rd_ok;
  logic [AW-1:0]    w_waddr;
  logic [AW-1:0]    w_raddr;
  logic [WIDTH-1:0] w_rdata;

  assign w_full  = (r_count == LP_DEPTH);
  assign w_empty = (r_count == '0);

  // A full buffer still takes a write when a read frees a slot the same edge.
  assign w_wr_ok = Wren & (~w_full | Rden);
  assign w_rd_ok = Rden & ~w_empty;

  if (MODE == MODE_LIFO) begin : g_lifo
    logic [AW-1:0] w_top;
    // Count == DEPTH truncates to 0, so top wraps to DEPTH-1.
    assign w_top   = r_count[AW-1:0] - AW'(1);
    assign w_raddr = w_top;
    // Push+pop replaces the old top in place.
    assign w_waddr = w_rd_ok ? w_top : r_count[AW-1:0];
  end else begin : g_fifo
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
        r_wptr <= '0;
        r_rptr <= '0;
      end else begin
        if (w_wr_ok) r_wptr <= r_wptr + AW'(1);
        if (w_rd_ok) r_rptr <= r_rptr + AW'(1);
      end
    end
    assign w_waddr = r_wptr;
    assign w_raddr = r_rptr;
  end

  buf_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .i_clk   (Clk),
    .i_we    (w_wr_ok),
    .i_waddr (w_waddr),
    .i_wdata (Datain),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_count   <= '0;
      r_dout    <= '0;
      r_rdvalid <= 1'b0;
    end else begin
      unique case ({w_wr_ok, w_rd_ok})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      // Async read sees pre-write contents, so push+pop returns old data.
      if (w_rd_ok) r_dout <= w_rdata;
      r_rdvalid <= w_rd_ok;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else if (Clrerr) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      if (Wren & ~w_wr_ok) r_ovf <= 1'b1;
      if (Rden & ~w_rd_ok) r_unf <= 1'b1;
    end
  end

  assign Dataout   = r_dout;
  assign Rdvalid   = r_rdvalid;
  assign Full      = w_full;
  assign Empty     = w_empty;
  assign Almfull   = (r_count >= LP_AF);
  assign Almempty  = (r_count <= LP_AE);
  assign Count     = r_count;
  assign Overflow  = r_ovf;
  assign Underflow = r_unf;

endmodule

// File: tb/tb_fifo_lifo_sc.sv
// tb_fifo_lifo_sc: table vectors, corner sequences and random traffic
// on a FIFO and a LIFO instance (DEPTH=4, WIDTH=8) against queue models.
module tb_fifo_lifo_sc;

  localparam int W = 8;
  localparam int D = 4;

  logic         Clk, Rst;
  logic [W-1:0] f_din, l_din;
  logic         f_wr, f_rd, f_clr, l_wr, l_rd, l_clr;
  logic [W-1:0] f_dout, l_dout;
  logic         f_rv, f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
  logic         l_rv, l_full, l_empty, l_af, l_ae, l_ovf, l_unf;
  logic [2:0]   f_cnt, l_cnt;

  fifo_lifo_sc #(.WIDTH(W), .DEPTH(D), .MODE(0)) u_fifo (
    .Clk(Clk), .Rst(Rst), .Datain(f_din), .Wren(f_wr), .Rden(f_rd),
    .Clrerr(f_clr), .Dataout(f_dout), .Rdvalid(f_rv), .Full(f_full),
    .Empty(f_empty), .Almfull(f_af), .Almempty(f_ae), .Count(f_cnt),
    .Overflow(f_ovf), .Underflow(f_unf)
  );

  fifo_lifo_sc #(.WIDTH(W), .DEPTH(D), .MODE(1)) u_lifo (
    .Clk(Clk), .Rst(Rst), .Datain(l_din), .Wren(l_wr), .Rden(l_rd),
    .Clrerr(l_clr), .Dataout(l_dout), .Rdvalid(l_rv), .Full(l_full),
    .Empty(l_empty), .Almfull(l_af), .Almempty(l_ae), .Count(l_cnt),
    .Overflow(l_ovf), .Underflow(l_unf)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference: queue contents plus last read word and sticky flags.
  logic [W-1:0] fq[$];
  logic [W-1:0] lq[$];
  logic [W-1:0] m_dout[2];
  bit           m_rv[2];
  bit           m_ovf[2];
  bit           m_unf[2];

  typedef struct {
    int           d;
    bit           wr, rd, clr;
    logic [W-1:0] din;
    logic [W-1:0] dout;
    bit           rv;
    int           cnt;
    bit           ovf, unf;
  } vec_t;

  vec_t tab[$];

  function automatic vec_t mk(int d, bit wr, bit rd, bit clr,
                              logic [W-1:0] din, logic [W-1:0] dout,
                              bit rv, int cnt, bit ovf, bit unf);
    vec_t v;
    v.d = d; v.wr = wr; v.rd = rd; v.clr = clr; v.din = din;
    v.dout = dout; v.rv = rv; v.cnt = cnt; v.ovf = ovf; v.unf = unf;
    return v;
  endfunction

  task automatic cmp(string nm, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cmp_all(string tag, int d, logic [W-1:0] edout, bit erv,
                         int ecnt, bit eovf, bit eunf);
    logic [W-1:0] a_dout;
    logic [2:0]   a_cnt;
    logic         a_rv, a_full, a_empty, a_af, a_ae, a_ovf, a_unf;
    if (d == 0) begin
      a_dout = f_dout; a_rv = f_rv; a_cnt = f_cnt; a_full = f_full;
      a_empty = f_empty; a_af = f_af; a_ae = f_ae;
      a_ovf = f_ovf; a_unf = f_unf;
    end else begin
      a_dout = l_dout; a_rv = l_rv; a_cnt = l_cnt; a_full = l_full;
      a_empty = l_empty; a_af = l_af; a_ae = l_ae;
      a_ovf = l_ovf; a_unf = l_unf;
    end
    cmp({tag, ".dout"},  int'(a_dout),  int'(edout));
    cmp({tag, ".rv"},    int'(a_rv),    int'(erv));
    cmp({tag, ".count"}, int'(a_cnt),   ecnt);
    cmp({tag, ".full"},  int'(a_full),  int'(ecnt == D));
    cmp({tag, ".empty"}, int'(a_empty), int'(ecnt == 0));
    cmp({tag, ".almf"},  int'(a_af),    int'(ecnt >= D - 2));
    cmp({tag, ".alme"},  int'(a_ae),    int'(ecnt <= 2));
    cmp({tag, ".ovf"},   int'(a_ovf),   int'(eovf));
    cmp({tag, ".unf"},   int'(a_unf),   int'(eunf));
  endtask

  task automatic model_step(int d, bit wr, bit rd, bit clr,
                            logic [W-1:0] din);
    int sz;
    bit wok, rok;
    sz  = (d == 0) ? fq.size() : lq.size();
    wok = wr && (sz < D || rd);
    rok = rd && (sz > 0);
    m_rv[d] = rok;
    if (rok) begin
      if (d == 0) m_dout[0] = fq.pop_front();
      else        m_dout[1] = lq.pop_back();
    end
    if (wok) begin
      if (d == 0) fq.push_back(din);
      else        lq.push_back(din);
    end
    if (clr) begin
      m_ovf[d] = 1'b0;
      m_unf[d] = 1'b0;
    end else begin
      if (wr && !wok) m_ovf[d] = 1'b1;
      if (rd && !rok) m_unf[d] = 1'b1;
    end
  endtask

  task automatic model_reset();
    fq.delete();
    lq.delete();
    for (int i = 0; i < 2; i++) begin
      m_dout[i] = '0; m_rv[i] = 0; m_ovf[i] = 0; m_unf[i] = 0;
    end
  endtask

  task automatic check_model(string tag, int d);
    int sz;
    sz = (d == 0) ? fq.size() : lq.size();
    cmp_all(tag, d, m_dout[d], m_rv[d], sz, m_ovf[d], m_unf[d]);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
    model_step(0, f_wr, f_rd, f_clr, f_din);
    model_step(1, l_wr, l_rd, l_clr, l_din);
  endtask

  task automatic drive(int d, bit wr, bit rd, bit clr, logic [W-1:0] din);
    f_wr = 0; f_rd = 0; f_clr = 0; f_din = '0;
    l_wr = 0; l_rd = 0; l_clr = 0; l_din = '0;
    if (d == 0) begin
      f_wr = wr; f_rd = rd; f_clr = clr; f_din = din;
    end else begin
      l_wr = wr; l_rd = rd; l_clr = clr; l_din = din;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // FIFO: fill, overflow, drain, underflow, clear, full push+pop, empty push+pop
    tab.push_back(mk(0,1,0,0,8'h0A, 8'h00,0,1,0,0));
    tab.push_back(mk(0,1,0,0,8'h0B, 8'h00,0,2,0,0));
    tab.push_back(mk(0,1,0,0,8'h0C, 8'h00,0,3,0,0));
    tab.push_back(mk(0,1,0,0,8'h0D, 8'h00,0,4,0,0));
    tab.push_back(mk(0,1,0,0,8'h55, 8'h00,0,4,1,0));
    tab.push_back(mk(0,0,1,0,8'h00, 8'h0A,1,3,1,0));
    tab.push_back(mk(0,0,1,0,8'h00, 8'h0B,1,2,1,0));
    tab.push_back(mk(0,0,1,0,8'h00, 8'h0C,1,1,1,0));
    tab.push_back(mk(0,0,1,0,8'h00, 8'h0D,1,0,1,0));
    tab.push_back(mk(0,0,1,0,8'h00, 8'h0D,0,0,1,1));
    tab.push_back(mk(0,0,0,1,8'h00, 8'h0D,0,0,0,0));
    tab.push_back(mk(0,1,0,0,8'h01, 8'h0D,0,1,0,0));
    tab.push_back(mk(0,1,0,0,8'h02, 8'h0D,0,2,0,0));
    tab.push_back(mk(0,1,0,0,8'h03, 8'h0D,0,3,0,0));
    tab.push_back(mk(0,1,0,0,8'h04, 8'h0D,0,4,0,0));
    tab.push_back(mk(0,1,1,0,8'h0E, 8'h01,1,4,0,0));
    tab.push_back(mk(0,0,1,0,8'h00, 8'h02,1,3,0,0));
    tab.push_back(mk(0,0,1,0,8'h00, 8'h03,1,2,0,0));
    tab.push_back(mk(0,0,1,0,8'h00, 8'h04,1,1,0,0));
    tab.push_back(mk(0,0,1,0,8'h00, 8'h0E,1,0,0,0));
    tab.push_back(mk(0,1,1,0,8'h06, 8'h0E,0,1,0,1));
    tab.push_back(mk(0,0,1,0,8'h00, 8'h06,1,0,0,1));
    tab.push_back(mk(0,0,0,1,8'h00, 8'h06,0,0,0,0));
    // LIFO: push 1,2,3 pop 3,2,1; push+pop replaces top; underflow; clear
    tab.push_back(mk(1,1,0,0,8'h01, 8'h00,0,1,0,0));
    tab.push_back(mk(1,1,0,0,8'h02, 8'h00,0,2,0,0));
    tab.push_back(mk(1,1,0,0,8'h03, 8'h00,0,3,0,0));
    tab.push_back(mk(1,0,1,0,8'h00, 8'h03,1,2,0,0));
    tab.push_back(mk(1,0,1,0,8'h00, 8'h02,1,1,0,0));
    tab.push_back(mk(1,0,1,0,8'h00, 8'h01,1,0,0,0));
    tab.push_back(mk(1,1,0,0,8'h04, 8'h01,0,1,0,0));
    tab.push_back(mk(1,1,0,0,8'h05, 8'h01,0,2,0,0));
    tab.push_back(mk(1,1,1,0,8'h09, 8'h05,1,2,0,0));
    tab.push_back(mk(1,0,1,0,8'h00, 8'h09,1,1,0,0));
    tab.push_back(mk(1,0,1,0,8'h00, 8'h04,1,0,0,0));
    tab.push_back(mk(1,0,1,0,8'h00, 8'h04,0,0,0,1));
    tab.push_back(mk(1,0,0,1,8'h00, 8'h04,0,0,0,0));

    drive(0, 0, 0, 0, '0);
    Rst = 1'b1;
    model_reset();
    repeat (2) @(negedge Clk);
    Rst = 1'b0;
    @(negedge Clk);
    cmp_all("rst_f", 0, 8'h00, 0, 0, 0, 0);
    cmp_all("rst_l", 1, 8'h00, 0, 0, 0, 0);

    for (int i = 0; i < tab.size(); i++) begin
      drive(tab[i].d, tab[i].wr, tab[i].rd, tab[i].clr, tab[i].din);
      tick();
      cmp_all($sformatf("tab%0d", i), tab[i].d, tab[i].dout, tab[i].rv,
              tab[i].cnt, tab[i].ovf, tab[i].unf);
    end

    // Wrap-around: pointers cycle the 4 slots more than twice.
    for (int k = 0; k < 10; k++) begin
      drive(0, 1, 0, 0, W'(k));
      tick();
      cmp($sformatf("wrap%0d.cnt", k), int'(f_cnt), 1);
      drive(0, 0, 1, 0, '0);
      tick();
      cmp_all($sformatf("wrap%0d", k), 0, W'(k), 1, 0, 0, 0);
    end

    // Async reset between edges with Count=3 and a live Rdvalid.
    for (int k = 0; k < 4; k++) begin
      drive(0, 1, 0, 0, W'(8'h21 + k));
      tick();
    end
    drive(0, 0, 1, 0, '0);
    tick();
    cmp_all("pre_rst", 0, 8'h21, 1, 3, 0, 0);
    #2;
    Rst = 1'b1;
    #1;
    cmp_all("async_rst", 0, 8'h00, 0, 0, 0, 0);
    model_reset();
    drive(0, 0, 0, 0, '0);
    @(negedge Clk);
    Rst = 1'b0;
    drive(0, 1, 0, 0, 8'h07);
    tick();
    drive(0, 0, 1, 0, '0);
    tick();
    cmp_all("post_rst", 0, 8'h07, 1, 0, 0, 0);

    // Random traffic on both instances against the queue models.
    for (int n = 0; n < 400; n++) begin
      f_wr  = ($urandom_range(0, 99) < 55);
      f_rd  = ($urandom_range(0, 99) < 50);
      f_clr = ($urandom_range(0, 15) == 0);
      f_din = W'($urandom);
      l_wr  = ($urandom_range(0, 99) < 50);
      l_rd  = ($urandom_range(0, 99) < 55);
      l_clr = ($urandom_range(0, 15) == 0);
      l_din = W'($urandom);
      tick();
      check_model($sformatf("rnd%0d_f", n), 0);
      check_model($sformatf("rnd%0d_l", n), 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
